cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single Common Data Bus among NREQ execution
//  units (ALU, mult, div, load/store), with a one-cycle registered CDB output.
//  Its Cdb_* outputs drive the ROB's Cdb_rd_tag/Cdb_valid/Cdb_data/Cdb_branch/
//  Cdb_branch_taken inputs and the reservation stations' tag snoop.
//  Accepts at most one result per cycle. Supports a flush for branch mispredict.
// PARAMETERS
//  NREQ   4   number of requesting execution units (2..8)
//  TAG_W  5   ROB tag width
//  DATA_W 32  result data width
// PORTS
//  clock             in   1            system clock, rising edge
//  reset             in   1            asynchronous, active-low reset
//  Req_valid         in   NREQ         unit i holds a finished result
//  Req_tag           in   NREQ*TAG_W   ROB tag of unit i, slice [i*TAG_W +: TAG_W]
//  Req_data          in   NREQ*DATA_W  result of unit i, slice [i*DATA_W +: DATA_W]
//  Req_branch        in   NREQ         unit i result is a branch
//  Req_branch_taken  in   NREQ         resolved direction for unit i branch
//  Req_ready         out  NREQ         one-hot grant; accept when Req_valid[i]&Req_ready[i]
//  Flush             in   1            mispredict flush, synchronous
//  Cdb_valid         out  1            CDB carries a valid result this cycle
//  Cdb_rd_tag        out  TAG_W        broadcast tag
//  Cdb_data          out  DATA_W       broadcast data
//  Cdb_branch        out  1            broadcast is a branch
//  Cdb_branch_taken  out  1            branch taken
//  Cdb_xfer_cnt      out  16           saturating count of accepted results
// BEHAVIOUR
//  - Reset (reset=0): all outputs and state 0 immediately, no clock needed.
//    Cdb_* = 0, Cdb_xfer_cnt = 0, rr_ptr = 0, Req_ready = 0.
//    Unaccepted requests remain with the requesters.
//  - State: rr_ptr (clog2(NREQ) bits), the output register, Cdb_xfer_cnt.
//    rr_ptr wraps from NREQ-1 to 0 by compare, not by overflow.
//  - Grant (combinational):
//    - Winner is the first i with Req_valid[i], scanning rr_ptr, rr_ptr+1, ...
//      cyclically.
//    - Req_ready is one-hot on the winner, or all 0 when there is no valid
//      request, Flush=1, or reset is asserted.
//    - Req_ready[i] is never 1 while Req_valid[i]=0.
//  - Handshake: a requester holds Req_valid and its payload stable until accepted.
//    It may drop Req_valid only after acceptance.
//  - On acceptance of winner w at edge k:
//    - At k+1, Cdb_valid=1 and Cdb_rd_tag/data/branch/branch_taken = payload of w.
//    - rr_ptr <= (w==NREQ-1) ? 0 : w+1.
//    - Cdb_xfer_cnt increments, holding at 16'hFFFF.
//  - No acceptance at edge k: Cdb_valid=0 at k+1; the other Cdb_* fields and
//    rr_ptr hold.
//  - Latency is 1 cycle from accept to broadcast. Throughput is 1 result/cycle,
//    back-to-back with no bubble.
//  - Fairness: a continuously valid requester is granted within NREQ cycles.
//  - Flush=1 at edge k:
//    - Nothing is accepted, so Cdb_valid=0 at k+1. rr_ptr holds.
//    - A Cdb_valid already on the bus during cycle k still completes.
//    - Requesters clear their own state on Flush.
//  - Simultaneous Flush and valid requests: Flush wins.
//  - Duplicate tags from two units are not checked; each is broadcast in its
//    own cycle.
//  - The branch fields pass through unmodified for non-branch results.
// TESTING
//  1. Drive reset=0 mid-stream with no clock -> all Cdb_* = 0, Req_ready = 0,
//     Cdb_xfer_cnt = 0. Release, then a single request from unit 0 -> grant to
//     unit 0.
//  2. After reset, Req_valid=4'b0010, tag=7, data=32'hDEADBEEF
//     -> Req_ready=4'b0010 the same cycle; next cycle Cdb_valid=1, tag=7,
//     data=DEADBEEF; rr_ptr=2.
//  3. All 4 valid, each re-asserting after its grant, for 8 cycles from reset
//     -> grant order 0,1,2,3,0,1,2,3; Cdb_valid high 8 consecutive cycles;
//     Cdb_xfer_cnt=8.
//  4. Units 1 and 3 valid with rr_ptr=2, Flush=1 for 2 cycles
//     -> Req_ready=0 and Cdb_valid=0. After Flush drops, unit 3 is granted
//     first, then unit 1.
//  5. Unit 2 with branch=1, taken=1, tag=5'd31
//     -> next cycle Cdb_branch=1, Cdb_branch_taken=1, Cdb_rd_tag=31.
//     Then a non-branch from unit 0 -> Cdb_branch=0.
//  6. Force Cdb_xfer_cnt to 16'hFFFE, then 3 accepts
//     -> counter reads FFFF and holds. Arbitration is unaffected.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
//------------------------------------------------------------------------------
// cdb_arbiter_if
// Request/grant bundle from the execution units plus the registered Common
// Data Bus broadcast.
// Rev 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        Req_valid;
  logic [NREQ*TAG_W-1:0]  Req_tag;
  logic [NREQ*DATA_W-1:0] Req_data;
  logic [NREQ-1:0]        Req_branch;
  logic [NREQ-1:0]        Req_branch_taken;
  logic [NREQ-1:0]        Req_ready;
  logic                   Flush;
  logic                   Cdb_valid;
  logic [TAG_W-1:0]       Cdb_rd_tag;
  logic [DATA_W-1:0]      Cdb_data;
  logic                   Cdb_branch;
  logic                   Cdb_branch_taken;
  logic [15:0]            Cdb_xfer_cnt;

  // Execution-unit side: drives requests and flush, observes grant and bus.
  modport master (
    output Req_valid, Req_tag, Req_data, Req_branch, Req_branch_taken, Flush,
    input  Req_ready, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch,
           Cdb_branch_taken, Cdb_xfer_cnt
  );

  // Arbiter side.
  modport slave (
    input  Req_valid, Req_tag, Req_data, Req_branch, Req_branch_taken, Flush,
    output Req_ready, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch,
           Cdb_branch_taken, Cdb_xfer_cnt
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the Common Data Bus. Grants one finished result per
// cycle and broadcasts it on the registered CDB one cycle after acceptance.
// Rev 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
  parameter int NREQ   = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset,   // asynchronous, active-low
  cdb_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [PTR_W:0]   NREQ_EXT = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W:0]    scan_idx;
  logic              found;
  logic              accept;
  logic [NREQ-1:0]   ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rd_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_branch;
  logic              cdb_branch_taken;
  logic [15:0]       xfer_cnt;

  // Cyclic scan from rr_ptr for the first valid requester; the extra index
  // bit lets the wrap be done by compare so non-power-of-two NREQ works.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_idx >= NREQ_EXT) scan_idx = scan_idx - NREQ_EXT;
      if (!found && bus.Req_valid[scan_idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Flush and reset both suppress the grant, so nothing is consumed from the
  // requesters while either is active.
  always_comb begin
    accept = found & ~bus.Flush & reset;
    ready  = '0;
    if (accept) ready[winner] = 1'b1;
  end

  // Output register, pointer advance and saturating transfer counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr           <= '0;
      cdb_valid        <= 1'b0;
      cdb_rd_tag       <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      xfer_cnt         <= '0;
    end else begin
      cdb_valid <= accept;
      if (accept) begin
        cdb_rd_tag       <= bus.Req_tag[int'(winner)*TAG_W +: TAG_W];
        cdb_data         <= bus.Req_data[int'(winner)*DATA_W +: DATA_W];
        cdb_branch       <= bus.Req_branch[winner];
        cdb_branch_taken <= bus.Req_branch_taken[winner];
        rr_ptr           <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
        if (xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

  assign bus.Req_ready        = ready;
  assign bus.Cdb_valid        = cdb_valid;
  assign bus.Cdb_rd_tag       = cdb_rd_tag;
  assign bus.Cdb_data         = cdb_data;
  assign bus.Cdb_branch       = cdb_branch;
  assign bus.Cdb_branch_taken = cdb_branch_taken;
  assign bus.Cdb_xfer_cnt     = xfer_cnt;

endmodule

`default_nettype wire
